alu_exec_writeback: RTL and testbench

Sequencing execute/writeback stage wrapped around the 32×32 two-read/one-write register file (`ReadAndWrite`).
- Accepts one register-to-register instruction at a time (opcode plus source and destination register numbers) through a valid/ready handshake.
- Drives the register file read ports, captures both operands, and computes the result. Simple ALU ops take a single execute cycle; MUL uses an iterative 32-step shift-add.
- Writes the result back through the register file write port as a single-cycle strobe.

---
 rtl/alu_exec_writeback_if.sv | 35 +++
 rtl/alu_exec_writeback.sv | 114 +++++++++++
 tb/tb_alu_exec_writeback.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_writeback_if.sv
// Instruction handshake, register-file read/write ports and status for alu_exec_writeback.
// slave is the execute stage's view; master is the upstream/register-file side.
interface alu_exec_writeback_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              InValid;
  logic              InReady;
  logic [3:0]        AluOp;
  logic [ADDR_W-1:0] SrcReg1;
  logic [ADDR_W-1:0] SrcReg2;
  logic [ADDR_W-1:0] DestReg;
  logic [ADDR_W-1:0] ReadRegNum1;
  logic [ADDR_W-1:0] ReadRegNum2;
  logic [WIDTH-1:0]  ReadOut1;
  logic [WIDTH-1:0]  ReadOut2;
  logic              WriteEn;
  logic [ADDR_W-1:0] WriteRegNum;
  logic [WIDTH-1:0]  RegData;
  logic              Done;
  logic              OpErr;
  logic              Busy;

  modport slave (
    input  InValid, AluOp, SrcReg1, SrcReg2, DestReg, ReadOut1, ReadOut2,
    output InReady, ReadRegNum1, ReadRegNum2, WriteEn, WriteRegNum, RegData,
           Done, OpErr, Busy
  );

  modport master (
    output InValid, AluOp, SrcReg1, SrcReg2, DestReg, ReadOut1, ReadOut2,
    input  InReady, ReadRegNum1, ReadRegNum2, WriteEn, WriteRegNum, RegData,
           Done, OpErr, Busy
  );
endinterface

// File: rtl/alu_exec_writeback.sv
// Execute/writeback stage around a 2R1W register file: ALU ops retire 3 cycles after acceptance, MUL 34.
// One instruction in flight; InReady only in IDLE, so upstream holds InValid until accepted.
module alu_exec_writeback #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic                 Clk,
  input logic                 Reset,
  alu_exec_writeback_if.slave bus
);
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

  state_t            r_state;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_src2;
  logic [ADDR_W-1:0] r_dest;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic [WIDTH-1:0]  w_alu;
  logic              w_illegal;
  logic [WIDTH-1:0]  w_acc_next;

  always_comb begin
    w_alu     = '0;
    w_illegal = 1'b0;
    case (r_op)
      4'd0: w_alu = r_op_a + r_op_b;
      4'd1: w_alu = r_op_a - r_op_b;
      4'd2: w_alu = r_op_a & r_op_b;
      4'd3: w_alu = r_op_a | r_op_b;
      4'd4: w_alu = r_op_a ^ r_op_b;
      4'd5: w_alu = {{(WIDTH-1){1'b0}}, ($signed(r_op_a) < $signed(r_op_b))};
      4'd6: w_alu = r_op_a << r_op_b[4:0];
      4'd7: w_alu = r_op_a >> r_op_b[4:0];
      default: w_illegal = 1'b1;
    endcase
  end

  // One shift-add step: OpA walks left, OpB walks right, bit 0 of OpB gates the add.
  assign w_acc_next = r_acc + (r_op_b[0] ? r_op_a : '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_dest   <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.InValid) begin
            r_op    <= bus.AluOp;
            r_src1  <= bus.SrcReg1;
            r_src2  <= bus.SrcReg2;
            r_dest  <= bus.DestReg;
            r_err   <= 1'b0;
            r_state <= READ;
          end
        end
        READ: begin
          r_op_a  <= bus.ReadOut1;
          r_op_b  <= bus.ReadOut2;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= (r_op == 4'd8) ? MUL : EXEC;
        end
        EXEC: begin
          r_result <= w_alu;
          r_err    <= w_illegal;
          r_state  <= WB;
        end
        MUL: begin
          r_acc  <= w_acc_next;
          r_op_a <= r_op_a << 1;
          r_op_b <= r_op_b >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_result <= w_acc_next;
            r_state  <= WB;
          end
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset gates InReady directly so an instruction is never taken in a reset cycle.
  assign bus.InReady     = (r_state == IDLE) && !Reset;
  assign bus.Busy        = (r_state != IDLE);
  assign bus.Done        = (r_state == WB);
  assign bus.WriteEn     = (r_state == WB) && !r_err;
  assign bus.OpErr       = (r_state == WB) && r_err;
  assign bus.ReadRegNum1 = r_src1;
  assign bus.ReadRegNum2 = r_src2;
  assign bus.WriteRegNum = r_dest;
  assign bus.RegData     = r_result;
endmodule

// File: tb/tb_alu_exec_writeback.sv
// Bench for alu_exec_writeback: register file plus a transaction-level model checked every cycle.
module tb_alu_exec_writeback;
  logic Clk;
  logic Reset;

  alu_exec_writeback_if #(.WIDTH(32), .ADDR_W(5)) bus();

  alu_exec_writeback #(.WIDTH(32), .ADDR_W(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Register file the stage drives; preloads take priority over the write port.
  logic [31:0] rf [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_dat;

  assign bus.ReadOut1 = rf[bus.ReadRegNum1];
  assign bus.ReadOut2 = rf[bus.ReadRegNum2];

  always @(posedge Clk) begin
    if (pl_en) rf[pl_addr] <= pl_dat;
    else if (bus.WriteEn) rf[bus.WriteRegNum] <= bus.RegData;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Transaction model: one instruction outstanding, retiring at a fixed latency.
  logic [31:0] mdl_rf [32];
  bit          pend = 0;
  int          acc_cyc = 0;
  int          wb_cyc = 0;
  bit          e_err = 0;
  logic [31:0] e_dat = '0;
  logic [4:0]  e_rd = '0;
  logic [4:0]  e_rn1 = '0;
  logic [4:0]  e_rn2 = '0;
  int          n_done = 0;
  int          n_err = 0;
  int          n_we = 0;
  int          last_lat = 0;
  int          acc_q[$];

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  initial forever begin
    bit exp_rdy, exp_busy, exp_done;
    @(negedge Clk);
    if (chk_on) begin
      exp_rdy  = !pend && !Reset;
      exp_busy = pend && (cyc > acc_cyc);
      exp_done = pend && (cyc == wb_cyc);
      chk("InReady", bus.InReady, exp_rdy);
      chk("Busy", bus.Busy, exp_busy);
      chk("Done", bus.Done, exp_done);
      chk("WriteEn", bus.WriteEn, exp_done && !e_err);
      chk("OpErr", bus.OpErr, exp_done && e_err);
      chk("ReadRegNum1", bus.ReadRegNum1, e_rn1);
      chk("ReadRegNum2", bus.ReadRegNum2, e_rn2);
      if (exp_done) begin
        chk("WriteRegNum", bus.WriteRegNum, e_rd);
        chk("RegData", bus.RegData, e_dat);
        n_done++;
        last_lat = cyc - acc_cyc;
        if (e_err) n_err++;
        else mdl_rf[e_rd] = e_dat;
        pend = 0;
      end
      if (bus.WriteEn) n_we++;
      if (pl_en) mdl_rf[pl_addr] = pl_dat;
      if (Reset) begin
        pend  = 0;
        e_rn1 = '0;
        e_rn2 = '0;
      end else if (exp_rdy && bus.InValid) begin
        acc_cyc = cyc;
        wb_cyc  = cyc + ((bus.AluOp == 4'd8) ? 34 : 3);
        e_err   = (bus.AluOp > 4'd8);
        e_dat   = ref_alu(bus.AluOp, mdl_rf[bus.SrcReg1], mdl_rf[bus.SrcReg2]);
        e_rd    = bus.DestReg;
        e_rn1   = bus.SrcReg1;
        e_rn2   = bus.SrcReg2;
        pend    = 1;
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_dat = d;
    @(posedge Clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input bit keep);
    bit ok;
    ok = 0;
    bus.AluOp = op;
    bus.SrcReg1 = rs1;
    bus.SrcReg2 = rs2;
    bus.DestReg = rd;
    bus.InValid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge Clk);
      ok = bus.InReady;
      @(posedge Clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep) bus.InValid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge Clk);
      ok = !pend;
    end
    if (!ok) chk("retire_timeout", 32'd0, 32'd1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, err0, q;
    logic [3:0] op;
    Reset = 1'b1;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_dat = '0;
    bus.InValid = 1'b0;
    bus.AluOp = '0;
    bus.SrcReg1 = '0;
    bus.SrcReg2 = '0;
    bus.DestReg = '0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      mdl_rf[i] = '0;
    end
    @(posedge Clk);
    #1 chk_on = 1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("reset_InReady", bus.InReady, 32'd1);
    chk("reset_RegData", bus.RegData, 32'd0);
    chk("reset_WriteRegNum", bus.WriteRegNum, 32'd0);
    @(posedge Clk);
    #1;

    preload(5'd9, 32'd75);
    preload(5'd28, 32'd20);
    send(4'd0, 5'd9, 5'd28, 5'd4, 0);
    wait_idle();
    chk("add_latency", last_lat, 32'd3);
    chk("add_r4", rf[4], 32'd95);
    chk("model_add_r4", mdl_rf[4], 32'd95);

    send(4'd1, 5'd28, 5'd9, 5'd5, 0);
    wait_idle();
    chk("sub_r5", rf[5], 32'hFFFF_FFC9);

    send(4'd8, 5'd9, 5'd28, 5'd6, 0);
    wait_idle();
    chk("mul_latency", last_lat, 32'd34);
    chk("mul_r6", rf[6], 32'd1500);
    chk("model_mul_r6", mdl_rf[6], 32'd1500);

    preload(5'd10, 32'hFFFF_FFFF);
    send(4'd8, 5'd10, 5'd10, 5'd11, 0);
    wait_idle();
    chk("mul_ones_r11", rf[11], 32'd1);

    preload(5'd1, 32'hFFFF_FFFF);
    preload(5'd2, 32'd1);
    send(4'd5, 5'd1, 5'd2, 5'd12, 0);
    wait_idle();
    chk("slt_r12", rf[12], 32'd1);

    preload(5'd2, 32'd4);
    preload(5'd3, 32'h8000_0000);
    preload(5'd13, 32'd1);
    send(4'd7, 5'd3, 5'd2, 5'd14, 0);
    wait_idle();
    chk("srl_r14", rf[14], 32'h0800_0000);
    send(4'd6, 5'd13, 5'd2, 5'd15, 0);
    wait_idle();
    chk("sll_r15", rf[15], 32'd16);

    // Two queued ops with InValid held high: r4 = 95, then r4 = r4 + r4.
    send(4'd0, 5'd9, 5'd28, 5'd4, 1);
    send(4'd0, 5'd4, 5'd4, 5'd4, 0);
    wait_idle();
    q = acc_q.size();
    chk("b2b_gap", acc_q[q-1] - acc_q[q-2], 32'd4);
    chk("b2b_r4", rf[4], 32'd190);

    preload(5'd7, 32'h0000_1234);
    err0 = n_err;
    send(4'd15, 5'd1, 5'd2, 5'd7, 0);
    wait_idle();
    chk("err_latency", last_lat, 32'd3);
    chk("err_pulses", n_err - err0, 32'd1);
    chk("err_r7_kept", rf[7], 32'h0000_1234);

    // Reset in cycle 10 of a MUL: the write must never happen.
    preload(5'd16, 32'hDEAD_BEEF);
    we0 = n_we;
    send(4'd8, 5'd9, 5'd28, 5'd16, 0);
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid_InReady", bus.InReady, 32'd1);
    chk("rst_mid_ReadRegNum1", bus.ReadRegNum1, 32'd0);
    chk("rst_mid_RegData", bus.RegData, 32'd0);
    repeat (40) @(posedge Clk);
    #1;
    chk("rst_mid_no_write", n_we - we0, 32'd0);
    chk("rst_mid_r16", rf[16], 32'hDEAD_BEEF);

    for (int i = 0; i < 32; i++) begin
      case (i % 4)
        0: preload(5'(i), $urandom);
        1: preload(5'(i), 32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
        2: preload(5'(i), 32'h8000_0000 >> $urandom_range(0, 31));
        default: preload(5'(i), 32'($urandom_range(0, 40)));
      endcase
    end
    for (int n = 0; n < 80; n++) begin
      q = $urandom_range(0, 19);
      op = (q < 18) ? 4'(q % 9) : 4'($urandom_range(9, 15));
      send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 0);
      if ($urandom_range(0, 1) == 1) wait_idle();
      if (n % 16 == 15) begin
        wait_idle();
        preload(5'($urandom_range(0, 31)), $urandom);
      end
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
